// File: rtl/wshb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wshb_arb_pkg
// Shared types and helpers for the two-master Wishbone arbiter.
//   arb_state_t       : arbiter ownership state (IDLE, GNT0, GNT1)
//   DEFAULT_MAX_BURST : default number of acks per tenure
//   sel_width()       : byte-select width for a given data width
//   cnt_width()       : burst counter width, kept at least 1 bit wide
// -----------------------------------------------------------------------------
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MAX_BURST = 64;

  function automatic int sel_width(input int dw);
    return dw / 8;
  endfunction

  // $clog2(1) is 0, which would give a zero-width counter for MAX_BURST=1.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// -----------------------------------------------------------------------------
// arb_burst_counter
// Counts events within a tenure and flags the last allowed one.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes priority over inc)
//   inc        : count one event; saturates at MAX_COUNT-1
//   count      : current count
//   term       : high while count == MAX_COUNT-1
// -----------------------------------------------------------------------------
module arb_burst_counter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_BURST,
  parameter int CW        = cnt_width(MAX_COUNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          term
);

  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

  // Saturating at the terminal value lets the owner keep streaming while the
  // peer is idle and still be preempted on the very next ack once it asks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !term) begin
      count <= count + 1'b1;
    end
  end

  assign term = (count == LAST);

endmodule

// File: rtl/wshb_arbiter.sv
// -----------------------------------------------------------------------------
// wshb_arbiter
// Two-master, one-slave classic Wishbone arbiter with bounded tenure.
// Master 0 is the VGA frame reader, master 1 the frame writer; the slave is
// the SDRAM controller. A grant is handed over after MAX_BURST acks when the
// other master is waiting, and only on an ack boundary.
//
// Ports:
//   clk, rst_n                 : Wishbone clock, asynchronous active-low reset
//   mN_cyc/stb/we/adr/dat_ms/sel : master N request side
//   mN_ack                     : slave ack, routed only to the granted master
//   mN_dat_sm                  : read data, both driven from s_dat_sm
//   s_cyc/stb/we/adr/dat_ms/sel : slave request side, muxed from the owner
//   s_ack, s_dat_sm            : slave response
//   grant                      : one-hot owner, 00 when idle
//
// Build option:
//   WSHB_ARB_RR_EN : when defined, a simultaneous request from IDLE goes to the
//                    master that was not granted last (round robin). When
//                    undefined, master 0 wins the tie.
// -----------------------------------------------------------------------------
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [AW-1:0]           m0_adr,
  input  logic [DW-1:0]           m0_dat_ms,
  input  logic [sel_width(DW)-1:0] m0_sel,
  output logic                    m0_ack,
  output logic [DW-1:0]           m0_dat_sm,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [AW-1:0]           m1_adr,
  input  logic [DW-1:0]           m1_dat_ms,
  input  logic [sel_width(DW)-1:0] m1_sel,
  output logic                    m1_ack,
  output logic [DW-1:0]           m1_dat_sm,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [AW-1:0]           s_adr,
  output logic [DW-1:0]           s_dat_ms,
  output logic [sel_width(DW)-1:0] s_sel,
  input  logic                    s_ack,
  input  logic [DW-1:0]           s_dat_sm,
  output logic [1:0]              grant
);

  localparam int CW = cnt_width(MAX_BURST);

  arb_state_t    state;
  arb_state_t    state_nx;
  logic          burst_tc;
  logic [CW-1:0] burst_cnt;

`ifdef WSHB_ARB_RR_EN
  // 1 = master 1 held the most recent grant; reset to 1 so the first tie
  // after reset goes to master 0.
  logic last_gnt;
`endif

  // Next owner. Releases are checked in order: owner dropped cyc, then
  // burst limit reached on an ack with the peer waiting.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
`ifdef WSHB_ARB_RR_EN
          state_nx = last_gnt ? GNT0 : GNT1;
`else
          state_nx = GNT0;
`endif
        end else if (m0_cyc) begin
          state_nx = GNT0;
        end else if (m1_cyc) begin
          state_nx = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          state_nx = m1_cyc ? GNT1 : IDLE;
        end else if (s_ack && burst_tc && m1_cyc) begin
          state_nx = GNT1;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          state_nx = m0_cyc ? GNT0 : IDLE;
        end else if (s_ack && burst_tc && m0_cyc) begin
          state_nx = GNT0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

`ifdef WSHB_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (state_nx == GNT0 && state != GNT0) begin
      last_gnt <= 1'b0;
    end else if (state_nx == GNT1 && state != GNT1) begin
      last_gnt <= 1'b1;
    end
  end
`endif

  // Every ownership change starts a fresh tenure; acks seen in IDLE are strays.
  arb_burst_counter #(
    .MAX_COUNT (MAX_BURST),
    .CW        (CW)
  ) u_burst_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_nx != state),
    .inc   (s_ack && (state != IDLE)),
    .count (burst_cnt),
    .term  (burst_tc)
  );

  // Slave side follows the owner combinationally. Outside a grant cyc/stb are
  // forced low, which also drops them the moment rst_n asserts.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = m0_we;
    s_adr    = m0_adr;
    s_dat_ms = m0_dat_ms;
    s_sel    = m0_sel;
    case (state)
      GNT0: begin
        s_cyc = m0_cyc;
        s_stb = m0_stb;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
      end
      default: ;
    endcase
  end

  assign m0_ack    = (state == GNT0) && s_ack;
  assign m1_ack    = (state == GNT1) && s_ack;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign grant     = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wshb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wshb_arbiter
// Directed bench for wshb_arbiter with MAX_BURST=4 and a slave that acks one
// cycle after it sees stb (so a streaming master is acked every other cycle).
// Expected tie-break follows WSHB_ARB_RR_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_wshb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  localparam logic [AW-1:0] M0_ADR = 32'h1000_0040;
  localparam logic [AW-1:0] M1_ADR = 32'h2000_0080;
  localparam logic [DW-1:0] M0_DAT = 32'hAAAA_0000;
  localparam logic [DW-1:0] M1_DAT = 32'h5555_1111;
  localparam logic [SW-1:0] M0_SEL = 4'hF;
  localparam logic [SW-1:0] M1_SEL = 4'h3;
  localparam logic [DW-1:0] S_DAT  = 32'hCAFE_F00D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_ms;
  logic [SW-1:0] m0_sel;
  logic          m0_ack;
  logic [DW-1:0] m0_dat_sm;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_ms;
  logic [SW-1:0] m1_sel;
  logic          m1_ack;
  logic [DW-1:0] m1_dat_sm;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_ms;
  logic [SW-1:0] s_sel;
  logic          s_ack;
  logic [DW-1:0] s_dat_sm;
  logic [1:0]    grant;

  logic slave_ack;
  logic stray_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wshb_arbiter #(
    .MAX_BURST (4),
    .AW        (AW),
    .DW        (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_cyc    (m0_cyc),
    .m0_stb    (m0_stb),
    .m0_we     (m0_we),
    .m0_adr    (m0_adr),
    .m0_dat_ms (m0_dat_ms),
    .m0_sel    (m0_sel),
    .m0_ack    (m0_ack),
    .m0_dat_sm (m0_dat_sm),
    .m1_cyc    (m1_cyc),
    .m1_stb    (m1_stb),
    .m1_we     (m1_we),
    .m1_adr    (m1_adr),
    .m1_dat_ms (m1_dat_ms),
    .m1_sel    (m1_sel),
    .m1_ack    (m1_ack),
    .m1_dat_sm (m1_dat_sm),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_ms  (s_dat_ms),
    .s_sel     (s_sel),
    .s_ack     (s_ack),
    .s_dat_sm  (s_dat_sm),
    .grant     (grant)
  );

  // Slave model: ack one cycle after a strobe, never two acks in a row.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) slave_ack <= 1'b0;
    else        slave_ack <= s_cyc && s_stb && !slave_ack;
  end

  assign s_ack    = slave_ack | stray_ack;
  assign s_dat_sm = S_DAT;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic on);
    m0_cyc = on;
    m0_stb = on;
  endtask

  task automatic drive_m1(input logic on);
    m1_cyc = on;
    m1_stb = on;
  endtask

  // Drop both masters and let the arbiter settle back to IDLE.
  task automatic go_idle();
    drive_m0(1'b0);
    drive_m1(1'b0);
    repeat (3) tick();
    total++;
    if (grant !== 2'b00) begin
      bad++;
      $display("[TB] FAIL idle_grant: got %b expected 00", grant);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    stray_ack = 1'b0;
    m0_we = 1'b0;  m0_adr = M0_ADR;  m0_dat_ms = M0_DAT;  m0_sel = M0_SEL;
    m1_we = 1'b1;  m1_adr = M1_ADR;  m1_dat_ms = M1_DAT;  m1_sel = M1_SEL;
    drive_m0(1'b1);
    drive_m1(1'b0);
    repeat (2) tick();
    total++;
    if (grant !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_grant: got %b expected 00", grant);
    end
    total++;
    if ({s_cyc, s_stb} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_cyc_stb: got %b expected 00", {s_cyc, s_stb});
    end
    total++;
    if ({m0_ack, m1_ack} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_acks: got %b expected 00", {m0_ack, m1_ack});
    end
    drive_m0(1'b0);
    rst_n = 1'b1;
    tick();
    total++;
    if (grant !== 2'b00) begin
      bad++;
      $display("[TB] FAIL post_reset_idle: got %b expected 00", grant);
    end
  endtask

  task automatic test_single_master();
    int acks = 0;
    int errs = 0;
    drive_m0(1'b1);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (grant !== 2'b01) errs++;
      if (m1_ack !== 1'b0) errs++;
      if (m0_ack === 1'b1) acks++;
      if (i == 0) begin
        total++;
        if (s_cyc !== 1'b1) begin
          bad++;
          $display("[TB] FAIL single_first_cyc: got %b expected 1", s_cyc);
        end
      end
    end
    total++;
    if (acks !== 100) begin
      bad++;
      $display("[TB] FAIL single_ack_count: got %0d expected 100", acks);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("[TB] FAIL single_grant_stable: got %0d errors expected 0", errs);
    end
    go_idle();
  endtask

  task automatic test_preempt();
    int seq[$];
    int exp_seq[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int both = 0;
    drive_m0(1'b1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (m0_ack === 1'b1) seq.push_back(0);
      if (m1_ack === 1'b1) seq.push_back(1);
      if (m0_ack === 1'b1 && m1_ack === 1'b1) both++;
      if (i == 3) drive_m1(1'b1);
      if (i == 7) begin
        total++;
        if (grant !== 2'b01) begin
          bad++;
          $display("[TB] FAIL preempt_hold: got %b expected 01", grant);
        end
      end
      if (i == 8) begin
        total++;
        if (grant !== 2'b10) begin
          bad++;
          $display("[TB] FAIL preempt_switch: got %b expected 10", grant);
        end
        total++;
        if ({s_adr, s_we, s_sel} !== {M1_ADR, 1'b1, M1_SEL}) begin
          bad++;
          $display("[TB] FAIL preempt_route: got %h/%b/%h expected %h/1/%h",
                   s_adr, s_we, s_sel, M1_ADR, M1_SEL);
        end
        total++;
        if (m0_ack !== 1'b0) begin
          bad++;
          $display("[TB] FAIL preempt_m0_ack: got %b expected 0", m0_ack);
        end
        total++;
        if ({m0_dat_sm, m1_dat_sm} !== {S_DAT, S_DAT}) begin
          bad++;
          $display("[TB] FAIL read_data: got %h/%h expected %h", m0_dat_sm, m1_dat_sm, S_DAT);
        end
      end
      if (i == 16) begin
        total++;
        if (grant !== 2'b01) begin
          bad++;
          $display("[TB] FAIL preempt_back: got %b expected 01", grant);
        end
      end
    end
    total++;
    if (both !== 0) begin
      bad++;
      $display("[TB] FAIL preempt_dual_ack: got %0d expected 0", both);
    end
    total++;
    if (seq.size() < 12) begin
      bad++;
      $display("[TB] FAIL preempt_ack_total: got %0d expected >=12", seq.size());
    end else begin
      int diff = 0;
      for (int k = 0; k < 12; k++) if (seq[k] != exp_seq[k]) diff++;
      if (diff != 0) begin
        bad++;
        $display("[TB] FAIL preempt_order: got %0d wrong owners expected 0", diff);
      end
    end
    go_idle();
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
`ifdef WSHB_ARB_RR_EN
    exp_g = 2'b10;
`else
    exp_g = 2'b01;
`endif
    drive_m0(1'b1);
    repeat (4) tick();
    go_idle();
    drive_m0(1'b1);
    drive_m1(1'b1);
    tick();
    total++;
    if (grant !== exp_g) begin
      bad++;
      $display("[TB] FAIL tie_break: got %b expected %b", grant, exp_g);
    end
    go_idle();
  endtask

  task automatic test_release();
    int acks = 0;
    logic switched = 1'b0;
    drive_m1(1'b1);
    tick();
    total++;
    if (grant !== 2'b10) begin
      bad++;
      $display("[TB] FAIL release_m1_grant: got %b expected 10", grant);
    end
    drive_m0(1'b1);
    tick();
    total++;
    if (m1_ack !== 1'b1) begin
      bad++;
      $display("[TB] FAIL release_m1_ack: got %b expected 1", m1_ack);
    end
    drive_m1(1'b0);
    tick();
    total++;
    if (grant !== 2'b01) begin
      bad++;
      $display("[TB] FAIL release_handover: got %b expected 01", grant);
    end
    drive_m1(1'b1);
    for (int j = 0; j < 20 && !switched; j++) begin
      tick();
      if (grant === 2'b10) switched = 1'b1;
      else if (m0_ack === 1'b1) acks++;
    end
    total++;
    if (!switched || acks != 4) begin
      bad++;
      $display("[TB] FAIL release_fresh_burst: got %0d acks switched=%b expected 4 acks switched=1",
               acks, switched);
    end
    go_idle();
  endtask

  task automatic test_stray_ack();
    stray_ack = 1'b1;
    #1;
    total++;
    if ({m0_ack, m1_ack} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL stray_forward: got %b expected 00", {m0_ack, m1_ack});
    end
    tick();
    stray_ack = 1'b0;
    tick();
    total++;
    if (grant !== 2'b00) begin
      bad++;
      $display("[TB] FAIL stray_state: got %b expected 00", grant);
    end
  endtask

  task automatic test_reset_mid();
    drive_m0(1'b1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_cyc, s_stb, grant} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_mid_drop: got cyc/stb/grant %b expected 0000",
               {s_cyc, s_stb, grant});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({grant, s_ack} !== 3'b010) begin
      bad++;
      $display("[TB] FAIL reset_mid_restart: got grant/ack %b expected 010", {grant, s_ack});
    end
    go_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_master();
    test_preempt();
    test_tie();
    test_release();
    test_stray_ack();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
